// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: widths, IR field positions,
// opcodes, sequencer states, opcode classes and the datapath strobe bundle.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned CPU_OPC_W  = 5;

  // IR field positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  localparam logic [CPU_OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [CPU_OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [CPU_OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [CPU_OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [CPU_OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [CPU_OPC_W-1:0] OP_SHL  = 5'b01000;
  localparam logic [CPU_OPC_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [CPU_OPC_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [CPU_OPC_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [CPU_OPC_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [CPU_OPC_W-1:0] OP_NOP  = 5'b11000;
  localparam logic [CPU_OPC_W-1:0] OP_HALT = 5'b11001;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_BINARY,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } opclass_t;

  // One bit per datapath transfer strobe
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic zlow_out;
    logic zhigh_out;
    logic lo_in;
    logic hi_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } ctrl_t;

  function automatic logic [CPU_OPC_W-1:0] ir_opcode(input logic [CPU_DATA_W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/opclass_decode.sv
// Maps a 5-bit opcode to its execution class; anything not in the opcode
// table is reported as CLS_ILLEGAL.
//   opcode    : IR[31:27]
//   opclass_c : combinational class result
module opclass_decode
  import cpu_pkg::*;
(
  input  logic [CPU_OPC_W-1:0] opcode,
  output opclass_t             opclass_c
);

  always_comb begin
    opclass_c = CLS_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: opclass_c = CLS_BINARY;
      OP_MUL, OP_DIV:                                 opclass_c = CLS_MULDIV;
      OP_NEG, OP_NOT:                                 opclass_c = CLS_UNARY;
      OP_NOP:                                         opclass_c = CLS_NOP;
      OP_HALT:                                        opclass_c = CLS_HALT;
      default:                                        opclass_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetch (T0..T2), then opcode-dependent
// execute steps (T3..T6), driving the datapath transfer strobes.
// Outputs are a decode of the registered state (plus IR opcode in T3..T6),
// so an asynchronous clear forces them all to 0 immediately.
//   clock    : rising-edge clock
//   clear    : asynchronous active-low reset
//   IR       : instruction register contents
//   mem_rdy  : memory read complete, only looked at in T1
//   PCout..Rout : datapath strobes
//   alu_op   : opcode in the ALU-operate step, 0 otherwise
//   run      : high while sequencing (not RESET/HALT)
//   illegal  : one-cycle pulse on undefined opcode
// Build option: define ILLEGAL_TRAP_EN to trap undefined opcodes into HALT
// with an illegal pulse; otherwise they execute as NOP and illegal is 0.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned OPC_W  = CPU_OPC_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] IR,
  input  logic              mem_rdy,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              Zin,
  output logic              PCin,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              LOin,
  output logic              HIin,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic [OPC_W-1:0]  alu_op,
  output logic              run,
  output logic              illegal
);

  state_t             state_q, state_d;
  logic               t1_wait_q, t1_wait_d;
  ctrl_t              ctrl_c;
  logic [OPC_W-1:0]   alu_op_c;
  logic               run_c;
  logic [OPC_W-1:0]   opcode;
  opclass_t           opclass;
`ifdef ILLEGAL_TRAP_EN
  logic               illegal_c;
`endif

  // Register-select fields are consumed by the datapath, not here
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[DATA_W-OPC_W-1:0];

  assign opcode = IR[DATA_W-1 -: OPC_W];

  opclass_decode u_opclass_decode (
    .opcode    (opcode),
    .opclass_c (opclass)
  );

  // State register; t1_wait_q marks T1 cycles after the first (PCin suppression)
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_RESET;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d   = state_q;
    t1_wait_d = 1'b0;
    ctrl_c    = '0;
    alu_op_c  = '0;
    run_c     = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    illegal_c = 1'b0;
`endif
    case (state_q)
      S_RESET: begin
        run_c   = 1'b0;
        state_d = S_T0;
      end
      S_T0: begin
        ctrl_c.pc_out = 1'b1;
        ctrl_c.mar_in = 1'b1;
        ctrl_c.inc_pc = 1'b1;
        ctrl_c.z_in   = 1'b1;
        state_d       = S_T1;
      end
      S_T1: begin
        ctrl_c.zlow_out = 1'b1;
        ctrl_c.pc_in    = ~t1_wait_q;
        ctrl_c.read     = 1'b1;
        ctrl_c.mdr_in   = 1'b1;
        if (mem_rdy) begin
          state_d = S_T2;
        end else begin
          t1_wait_d = 1'b1;
        end
      end
      S_T2: begin
        ctrl_c.mdr_out = 1'b1;
        ctrl_c.ir_in   = 1'b1;
        state_d        = S_T3;
      end
      S_T3: begin
        state_d = S_T0;
        case (opclass)
          CLS_BINARY: begin
            ctrl_c.grb   = 1'b1;
            ctrl_c.r_out = 1'b1;
            ctrl_c.y_in  = 1'b1;
            state_d      = S_T4;
          end
          CLS_MULDIV: begin
            ctrl_c.gra   = 1'b1;
            ctrl_c.r_out = 1'b1;
            ctrl_c.y_in  = 1'b1;
            state_d      = S_T4;
          end
          CLS_UNARY: begin
            ctrl_c.grb   = 1'b1;
            ctrl_c.r_out = 1'b1;
            ctrl_c.z_in  = 1'b1;
            alu_op_c     = opcode;
            state_d      = S_T4;
          end
          CLS_HALT: state_d = S_HALT;
          CLS_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
            illegal_c = 1'b1;
            state_d   = S_HALT;
`else
            state_d   = S_T0;
`endif
          end
          default: state_d = S_T0;
        endcase
      end
      S_T4: begin
        state_d = S_T0;
        case (opclass)
          CLS_BINARY: begin
            ctrl_c.grc   = 1'b1;
            ctrl_c.r_out = 1'b1;
            ctrl_c.z_in  = 1'b1;
            alu_op_c     = opcode;
            state_d      = S_T5;
          end
          CLS_MULDIV: begin
            ctrl_c.grb   = 1'b1;
            ctrl_c.r_out = 1'b1;
            ctrl_c.z_in  = 1'b1;
            alu_op_c     = opcode;
            state_d      = S_T5;
          end
          CLS_UNARY: begin
            ctrl_c.zlow_out = 1'b1;
            ctrl_c.gra      = 1'b1;
            ctrl_c.r_in     = 1'b1;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T0;
        case (opclass)
          CLS_BINARY: begin
            ctrl_c.zlow_out = 1'b1;
            ctrl_c.gra      = 1'b1;
            ctrl_c.r_in     = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl_c.zlow_out = 1'b1;
            ctrl_c.lo_in    = 1'b1;
            state_d         = S_T6;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T6: begin
        ctrl_c.zhigh_out = 1'b1;
        ctrl_c.hi_in     = 1'b1;
        state_d          = S_T0;
      end
      S_HALT: begin
        run_c   = 1'b0;
        state_d = S_HALT;
      end
      default: begin
        run_c   = 1'b0;
        state_d = S_RESET;
      end
    endcase
  end

  assign PCout    = ctrl_c.pc_out;
  assign MARin    = ctrl_c.mar_in;
  assign IncPC    = ctrl_c.inc_pc;
  assign Zin      = ctrl_c.z_in;
  assign PCin     = ctrl_c.pc_in;
  assign Read     = ctrl_c.read;
  assign MDRin    = ctrl_c.mdr_in;
  assign MDRout   = ctrl_c.mdr_out;
  assign IRin     = ctrl_c.ir_in;
  assign Yin      = ctrl_c.y_in;
  assign Zlowout  = ctrl_c.zlow_out;
  assign Zhighout = ctrl_c.zhigh_out;
  assign LOin     = ctrl_c.lo_in;
  assign HIin     = ctrl_c.hi_in;
  assign Gra      = ctrl_c.gra;
  assign Grb      = ctrl_c.grb;
  assign Grc      = ctrl_c.grc;
  assign Rin      = ctrl_c.r_in;
  assign Rout     = ctrl_c.r_out;
  assign alu_op   = alu_op_c;
  assign run      = run_c;
`ifdef ILLEGAL_TRAP_EN
  assign illegal  = illegal_c;
`else
  assign illegal  = 1'b0;
`endif

endmodule
